sa_result_serializer: RTL and testbench

//  Next-generation systolic-array output path: snapshots the full south-edge result vector
//  (COL accumulators of W_ACC bits) on the last-row data-valid strobe and streams it as bytes

---
 rtl/sa_result_serializer.sv | 133 +++++++++++++
 tb/tb_sa_result_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_serializer.sv
// sa_result_serializer
//  Captures the south-edge result vector of the systolic array on i_cap and
//  streams it byte by byte into a uart_tx-style transmitter. Byte k of a frame
//  is snapshot[k*W_DATA +: W_DATA], so column 0 goes first and each column is
//  sent LSB byte first. The transmitter acknowledges each byte with i_tx_done.
//  Optional feature macro: SER_CHECKSUM_EN appends one XOR checksum byte.
module sa_result_serializer #(
  parameter int COL    = 56,
  parameter int W_ACC  = 32,
  parameter int W_DATA = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cap,
  input  logic [COL*W_ACC-1:0]   i_data,
  input  logic                   i_tx_done,
  output logic                   o_tx_dv,
  output logic [W_DATA-1:0]      o_tx_byte,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_overrun
);

  localparam int BPW    = W_ACC / W_DATA;
  localparam int NBYTES = COL * BPW;
  localparam int CW     = $clog2(NBYTES + 1);
`ifdef SER_CHECKSUM_EN
  localparam int LAST   = NBYTES;
`else
  localparam int LAST   = NBYTES - 1;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [COL*W_ACC-1:0]   snap_q;
  logic                   tx_dv_q;
  logic [W_DATA-1:0]      tx_byte_q;
  logic                   busy_q;
  logic                   fd_q;
  logic                   ovr_q;
`ifdef SER_CHECKSUM_EN
  logic [W_DATA-1:0]      csum_q;
`endif

  // Index and contents of the byte that follows the one in flight. Since
  // W_ACC is a whole number of bytes, column/byte addressing collapses to a
  // flat byte index into the snapshot.
  logic [CW-1:0]          cnt_d;
  logic [W_DATA-1:0]      byte_d;

  assign cnt_d = cnt_q + CW'(1);

  // Byte mux over the snapshot; the index one past the payload selects the checksum.
  always_comb begin
    byte_d = '0;
    for (int k = 0; k < NBYTES; k++)
      if (cnt_d == CW'(k)) byte_d = snap_q[k*W_DATA +: W_DATA];
`ifdef SER_CHECKSUM_EN
    if (cnt_d == CW'(NBYTES)) byte_d = csum_q;
`endif
  end

  // Frame FSM; all outputs are registered and change with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      tx_dv_q <= 1'b0;
      fd_q    <= 1'b0;
      // A capture arriving mid-frame is dropped but remembered.
      if (i_cap && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (i_cap) begin
            snap_q    <= i_data;
            cnt_q     <= '0;
            tx_byte_q <= i_data[W_DATA-1:0];
            tx_dv_q   <= 1'b1;
            busy_q    <= 1'b1;
`ifdef SER_CHECKSUM_EN
            csum_q    <= '0;
`endif
            state_q   <= SEND;
          end
        end
        SEND: begin
`ifdef SER_CHECKSUM_EN
          // Fold each payload byte in as it is offered; the checksum byte itself is excluded.
          if (cnt_q < CW'(NBYTES)) csum_q <= csum_q ^ tx_byte_q;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            if (cnt_q == CW'(LAST)) begin
              fd_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q     <= cnt_d;
              tx_byte_q <= byte_d;
              tx_dv_q   <= 1'b1;
              state_q   <= SEND;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_dv      = tx_dv_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_frame_done = fd_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_sa_result_serializer.sv
// tb_sa_result_serializer
//  Directed bench for a 2-column, 32-bit, byte-wide serializer. A transmitter
//  model answers every o_tx_dv with i_tx_done five cycles later; expected bytes
//  are queued at capture time and popped as the DUT offers them.
module tb_sa_result_serializer;

  localparam int COL = 2, W_ACC = 32, W_DATA = 8;
  localparam int NB  = COL * W_ACC / W_DATA;
`ifdef SER_CHECKSUM_EN
  localparam int FL  = NB + 1;
`else
  localparam int FL  = NB;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic                  i_cap = 1'b1;
  logic [COL*W_ACC-1:0]  i_data = '0;
  logic                  i_tx_done = 1'b0;
  logic                  o_tx_dv;
  logic [W_DATA-1:0]     o_tx_byte;
  logic                  o_busy;
  logic                  o_frame_done;
  logic                  o_overrun;

  sa_result_serializer #(.COL(COL), .W_ACC(W_ACC), .W_DATA(W_DATA)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cap(i_cap), .i_data(i_data),
    .i_tx_done(i_tx_done), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int               vectors = 0;
  int               miscompares = 0;
  int               bytes_total = 0;
  logic [W_DATA-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expected bytes of a frame and pulse i_cap for one cycle.
  task automatic start_frame(input logic [COL*W_ACC-1:0] d);
    logic [W_DATA-1:0] cs;
    cs = '0;
    @(negedge i_clk);
    i_data = d;
    i_cap  = 1'b1;
    for (int k = 0; k < NB; k++) begin
      sb.push_back(d[k*W_DATA +: W_DATA]);
      cs ^= d[k*W_DATA +: W_DATA];
    end
`ifdef SER_CHECKSUM_EN
    sb.push_back(cs);
`endif
    @(negedge i_clk);
    i_cap = 1'b0;
    check("latency_dv", 32'(o_tx_dv), 32'd1);
    check("first_byte", 32'(o_tx_byte), 32'(d[W_DATA-1:0]));
  endtask

  // Wait (bounded) for o_frame_done, optionally scrambling i_data meanwhile.
  task automatic wait_fd(input bit scramble);
    int n;
    n = 0;
    while (o_frame_done !== 1'b1 && n < 300) begin
      @(negedge i_clk);
      if (scramble) i_data = {$urandom, $urandom};
      n++;
    end
    check("frame_done_seen", 32'(o_frame_done), 32'd1);
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (bytes_total < target && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    check("bytes_reached", 32'(bytes_total >= target), 32'd1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    repeat (cycles) @(negedge i_clk);
    check(tag, 32'(o_busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    sb.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_ovr", 32'(o_overrun), 32'd0);
  endtask

  initial begin
    int base;
    logic [COL*W_ACC-1:0] d0;
    d0 = {32'h88776655, 32'h44332211};

    // Transmitter model plus output monitor/scoreboard, sampling 1 time unit after each edge.
    fork
      begin
        int  cnt;
        bit  was_done, prev_dv;
        cnt = 0;
        prev_dv = 1'b0;
        forever begin
          @(posedge i_clk);
          #1;
          was_done = i_tx_done;
          if (o_tx_dv === 1'b1) begin
            check("dv_expected", 32'(sb.size() != 0), 32'd1);
            check("dv_single", 32'(prev_dv), 32'd0);
            if (sb.size() != 0) check("byte", 32'(o_tx_byte), 32'(sb.pop_front()));
            bytes_total++;
          end
          if (o_frame_done === 1'b1) check("fd_after_done", 32'(was_done), 32'd1);
          prev_dv = (o_tx_dv === 1'b1);
          i_tx_done = 1'b0;
          if (i_rst) cnt = 0;
          else begin
            if (cnt > 0) begin
              cnt--;
              if (cnt == 0) i_tx_done = 1'b1;
            end
            if (o_tx_dv === 1'b1) cnt = 5;
          end
        end
      end
    join_none

    // 1: reset held with i_cap asserted
    repeat (3) begin
      @(posedge i_clk);
      @(negedge i_clk);
      check("rst_dv", 32'(o_tx_dv), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_fd", 32'(o_frame_done), 32'd0);
      check("rst_ovr", 32'(o_overrun), 32'd0);
      check("rst_byte", 32'(o_tx_byte), 32'd0);
    end
    i_rst = 1'b0;
    i_cap = 1'b0;
    idle_check("idle_after_rst", 4);

    // 2/3: basic frame (with checksum byte 0x88 when enabled)
    base = bytes_total;
    start_frame(d0);
    check("busy_in_frame", 32'(o_busy), 32'd1);
    wait_fd(1'b0);
    idle_check("busy_after_frame", 1);
    check("frame_len", 32'(bytes_total - base), 32'(FL));
    check("no_ovr", 32'(o_overrun), 32'd0);

    // 4a: capture during byte 3's WAIT with different data
    base = bytes_total;
    start_frame({32'hDEADBEEF, 32'hA5C3E1F0});
    wait_bytes(base + 4);
    @(negedge i_clk);
    i_data = {32'h01020304, 32'h05060708};
    i_cap  = 1'b1;
    @(negedge i_clk);
    i_cap = 1'b0;
    check("ovr_set", 32'(o_overrun), 32'd1);
    wait_fd(1'b0);
    idle_check("no_second_frame", 20);
    check("ovr_len", 32'(bytes_total - base), 32'(FL));
    check("ovr_sticky", 32'(o_overrun), 32'd1);

    // 4b: capture in the DONE cycle itself
    do_reset();
    base = bytes_total;
    start_frame(d0);
    wait_fd(1'b0);
    i_cap = 1'b1;
    @(negedge i_clk);
    i_cap = 1'b0;
    check("ovr_done_cycle", 32'(o_overrun), 32'd1);
    idle_check("done_cap_ignored", 20);
    check("done_cap_len", 32'(bytes_total - base), 32'(FL));

    // 5: i_data churns every cycle after capture
    do_reset();
    start_frame({32'h13579BDF, 32'h2468ACE0});
    wait_fd(1'b1);
    idle_check("snap_idle", 2);
    check("snap_no_ovr", 32'(o_overrun), 32'd0);

    // 6: reset during byte 4's WAIT, then restart from byte 0
    base = bytes_total;
    start_frame(d0);
    wait_bytes(base + 5);
    @(negedge i_clk);
    i_rst = 1'b1;
    sb.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    check("abort_dv", 32'(o_tx_dv), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    repeat (8) @(negedge i_clk);
    check("abort_quiet", 32'(bytes_total - base), 32'd5);
    base = bytes_total;
    start_frame(d0);
    wait_fd(1'b0);
    idle_check("restart_idle", 2);
    check("restart_len", 32'(bytes_total - base), 32'(FL));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
